// File: rtl/bank_scheduler_nport_if.sv
// Bus bundle for one bank scheduler instance.
// Requester side: request, grant and read response. Bank side: registered BRAM command and read data.
interface bank_scheduler_nport_if #(
    parameter int NUM_PORTS       = 4,
    parameter int ADDR_WIDTH      = 13,
    parameter int BANK_ADDR_WIDTH = 11,
    parameter int DATA_WIDTH      = 32,
    parameter int CNT_WIDTH       = 16
);
    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]            req_we;
    logic [NUM_PORTS-1:0]            req_ready;
    logic [NUM_PORTS-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]           rsp_rdata;
    logic                            mem_en;
    logic                            mem_we;
    logic [BANK_ADDR_WIDTH-1:0]      mem_addr;
    logic [DATA_WIDTH-1:0]           mem_wdata;
    logic [DATA_WIDTH-1:0]           mem_rdata;
    logic [CNT_WIDTH-1:0]            conflict_cnt;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_we, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt
    );
endinterface

// File: rtl/bank_scheduler_nport.sv
// N-port arbiter in front of one BRAM bank.
// It grants one in-window request per cycle, registers the bank command, returns tagged read data and counts contention.
module bank_scheduler_nport #(
    parameter int NUM_PORTS       = 4,
    parameter int ADDR_WIDTH      = 13,
    parameter int BANK_ADDR_WIDTH = 11,
    parameter int DATA_WIDTH      = 32,
    parameter int LOWER_ADDR      = 0,
    parameter int UPPER_ADDR      = 2047,
    parameter int RR_MODE         = 1,
    parameter int MEM_LATENCY     = 1,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    bank_scheduler_nport_if.slave bus
);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int DEPTH = MEM_LATENCY + 1;
    localparam logic [ADDR_WIDTH-1:0] LO   = ADDR_WIDTH'(LOWER_ADDR);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(UPPER_ADDR - LOWER_ADDR);

    logic [ADDR_WIDTH-1:0]      offset [NUM_PORTS];
    logic [NUM_PORTS-1:0]       elig;
    logic                       grant_vld;
    logic [PTR_W-1:0]           grant_idx;
    logic [PTR_W-1:0]           cand;
    logic                       multi;

    logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic                       mem_en_q, mem_we_q;
    logic [BANK_ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0]      mem_wdata_q;
    logic [DEPTH-1:0]           pipe_vld_q;
    logic [PTR_W-1:0]           pipe_idx_q [DEPTH];
    logic [NUM_PORTS-1:0]       rsp_valid_q;
    logic [DATA_WIDTH-1:0]      rsp_rdata_q;

    // A single unsigned compare on the wrapped offset covers both window bounds.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            offset[i] = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] - LO;
            elig[i]   = bus.req_valid[i] && (offset[i] <= SPAN);
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (RR_MODE != 0)
                cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_PORTS);
            else
                cand = PTR_W'(k);
            if (!grant_vld && elig[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (RR_MODE != 0 && grant_vld)
            rr_ptr_d = (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx + PTR_W'(1);
        multi = |(elig & (elig - NUM_PORTS'(1)));
        cnt_d = (multi && cnt_q != '1) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            pipe_vld_q  <= '0;
            for (int s = 0; s < DEPTH; s++) pipe_idx_q[s] <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            mem_en_q <= grant_vld;
            mem_we_q <= grant_vld && bus.req_we[grant_idx];
            if (grant_vld) begin
                mem_addr_q  <= offset[grant_idx][BANK_ADDR_WIDTH-1:0];
                mem_wdata_q <= bus.req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            // Stage s is valid in cycle grant+1+s, so the last stage lines up with mem_rdata.
            pipe_vld_q[0] <= grant_vld && !bus.req_we[grant_idx];
            pipe_idx_q[0] <= grant_idx;
            for (int s = 1; s < DEPTH; s++) begin
                pipe_vld_q[s] <= pipe_vld_q[s-1];
                pipe_idx_q[s] <= pipe_idx_q[s-1];
            end
            rsp_valid_q <= pipe_vld_q[DEPTH-1] ? (NUM_PORTS'(1) << pipe_idx_q[DEPTH-1]) : '0;
            if (pipe_vld_q[DEPTH-1])
                rsp_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.req_ready    = (grant_vld && !rst) ? (NUM_PORTS'(1) << grant_idx) : '0;
    assign bus.mem_en       = mem_en_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_bank_scheduler_nport.sv
// Bench with two scheduler instances: round-robin on bank 0..2047, and fixed-priority on bank 2048..4095 with a 4-bit counter.
// Random holding requesters and a behavioural bank feed both; a transaction-level model predicts every output.
module tb_bank_scheduler_nport;
    localparam int N    = 4;
    localparam int AW   = 13;
    localparam int BAW  = 11;
    localparam int DW   = 32;
    localparam int LAT0 = 1;
    localparam int LAT1 = 2;
    localparam int NCYC = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bank_scheduler_nport_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .BANK_ADDR_WIDTH(BAW),
                              .DATA_WIDTH(DW), .CNT_WIDTH(16)) bus0 ();
    bank_scheduler_nport_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .BANK_ADDR_WIDTH(BAW),
                              .DATA_WIDTH(DW), .CNT_WIDTH(4)) bus1 ();

    bank_scheduler_nport #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .BANK_ADDR_WIDTH(BAW), .DATA_WIDTH(DW),
                           .LOWER_ADDR(0), .UPPER_ADDR(2047), .RR_MODE(1),
                           .MEM_LATENCY(LAT0), .CNT_WIDTH(16))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

    bank_scheduler_nport #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .BANK_ADDR_WIDTH(BAW), .DATA_WIDTH(DW),
                           .LOWER_ADDR(2048), .UPPER_ADDR(4095), .RR_MODE(0),
                           .MEM_LATENCY(LAT1), .CNT_WIDTH(4))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Requester stimulus, per instance
    logic [N-1:0]  valid_s [2];
    logic [N-1:0]  we_s    [2];
    logic [AW-1:0] addr_s  [2][N];
    logic [DW-1:0] wdata_s [2][N];

    always_comb begin
        bus0.req_valid = valid_s[0];
        bus0.req_we    = we_s[0];
        bus0.req_addr  = '0;
        bus0.req_wdata = '0;
        bus1.req_valid = valid_s[1];
        bus1.req_we    = we_s[1];
        bus1.req_addr  = '0;
        bus1.req_wdata = '0;
        for (int p = 0; p < N; p++) begin
            bus0.req_addr[p*AW +: AW]  = addr_s[0][p];
            bus0.req_wdata[p*DW +: DW] = wdata_s[0][p];
            bus1.req_addr[p*AW +: AW]  = addr_s[1][p];
            bus1.req_wdata[p*DW +: DW] = wdata_s[1][p];
        end
    end

    // Observed outputs, gathered so the model loop can index by instance
    logic [N-1:0]   rdy_obs   [2];
    logic [N-1:0]   rspv_obs  [2];
    logic [DW-1:0]  rspd_obs  [2];
    logic           en_obs    [2];
    logic           we_obs    [2];
    logic [BAW-1:0] maddr_obs [2];
    logic [DW-1:0]  mwd_obs   [2];
    logic [15:0]    cnt_obs   [2];

    assign rdy_obs[0]   = bus0.req_ready;
    assign rdy_obs[1]   = bus1.req_ready;
    assign rspv_obs[0]  = bus0.rsp_valid;
    assign rspv_obs[1]  = bus1.rsp_valid;
    assign rspd_obs[0]  = bus0.rsp_rdata;
    assign rspd_obs[1]  = bus1.rsp_rdata;
    assign en_obs[0]    = bus0.mem_en;
    assign en_obs[1]    = bus1.mem_en;
    assign we_obs[0]    = bus0.mem_we;
    assign we_obs[1]    = bus1.mem_we;
    assign maddr_obs[0] = bus0.mem_addr;
    assign maddr_obs[1] = bus1.mem_addr;
    assign mwd_obs[0]   = bus0.mem_wdata;
    assign mwd_obs[1]   = bus1.mem_wdata;
    assign cnt_obs[0]   = 16'(bus0.conflict_cnt);
    assign cnt_obs[1]   = 16'(bus1.conflict_cnt);

    // Behavioural BRAMs driven by the DUT's registered command
    logic [DW-1:0] bmem0 [2048];
    logic [DW-1:0] bmem1 [2048];
    logic [DW-1:0] rd_pipe0 [LAT0];
    logic [DW-1:0] rd_pipe1 [LAT1];

    always @(posedge clk) begin
        if (bus0.mem_en) begin
            if (bus0.mem_we) bmem0[bus0.mem_addr] = bus0.mem_wdata;
            else             rd_pipe0[0] <= bmem0[bus0.mem_addr];
        end
        for (int k = 1; k < LAT0; k++) rd_pipe0[k] <= rd_pipe0[k-1];
    end

    always @(posedge clk) begin
        if (bus1.mem_en) begin
            if (bus1.mem_we) bmem1[bus1.mem_addr] = bus1.mem_wdata;
            else             rd_pipe1[0] <= bmem1[bus1.mem_addr];
        end
        for (int k = 1; k < LAT1; k++) rd_pipe1[k] <= rd_pipe1[k-1];
    end

    assign bus0.mem_rdata = rd_pipe0[LAT0-1];
    assign bus1.mem_rdata = rd_pipe1[LAT1-1];

    // Reference model state
    typedef struct {
        int            inst;
        int            due;
        int            port;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          rq [$];
    logic [DW-1:0] ref_mem [2][2048];
    int            ptr   [2];
    int            cnt   [2];
    bit            e_en  [2];
    bit            e_we  [2];
    int            e_addr [2];
    logic [DW-1:0] e_wdata [2];
    bit            pend  [2][N];
    bit            gnt_flag [2][N];
    bit            rst_last;
    int            cyc_now;
    int            n_chk = 0;
    int            n_err = 0;

    function automatic int lo_of(int i);  return (i == 0) ? 0 : 2048;     endfunction
    function automatic int hi_of(int i);  return (i == 0) ? 2047 : 4095;  endfunction
    function automatic bit rr_of(int i);  return (i == 0);                endfunction
    function automatic int lat_of(int i); return (i == 0) ? LAT0 : LAT1;  endfunction
    function automatic int max_of(int i); return (i == 0) ? 65535 : 15;   endfunction

    function automatic bit in_win(int i, logic [AW-1:0] a);
        return (int'(a) >= lo_of(i)) && (int'(a) <= hi_of(i));
    endfunction

    function automatic int pick_addr(int i, bit in_only);
        int r;
        r = in_only ? 5 : int'($urandom_range(0, 7));
        case (r)
            0:       return lo_of(i) - 1;
            1:       return lo_of(i);
            2:       return hi_of(i);
            3:       return hi_of(i) + 1;
            4:       return int'($urandom_range(0, 8191));
            default: return lo_of(i) + int'($urandom_range(0, 2047));
        endcase
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc_now, obs, exp);
        end
    endtask

    task automatic drive_inst(int i, int c);
        bit burst;
        burst = (c >= 3 && c < 20) || (c >= 402 && c < 420);
        for (int p = 0; p < N; p++) begin
            if (gnt_flag[i][p]) pend[i][p] = 1'b0;
            // Out-of-window requesters are served elsewhere; let them eventually move on.
            if (pend[i][p] && !in_win(i, addr_s[i][p]) && $urandom_range(0, 3) == 0)
                pend[i][p] = 1'b0;
            if (!pend[i][p] && (burst || $urandom_range(0, 2) == 0)) begin
                pend[i][p]    = 1'b1;
                addr_s[i][p]  = AW'(pick_addr(i, burst));
                we_s[i][p]    = burst ? 1'b0 : ($urandom_range(0, 2) == 0);
                wdata_s[i][p] = $urandom;
            end
            valid_s[i][p] = pend[i][p];
        end
    endtask

    task automatic check_and_step(int i, int c);
        int            g;
        int            ne;
        int            idx;
        int            loc;
        logic [N-1:0]  exp_rv;
        string         t;
        t  = (i == 0) ? "u0" : "u1";
        g  = -1;
        ne = 0;
        for (int p = 0; p < N; p++)
            if (valid_s[i][p] && in_win(i, addr_s[i][p])) ne++;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = rr_of(i) ? (ptr[i] + k) % N : k;
                if (g < 0 && valid_s[i][p] && in_win(i, addr_s[i][p])) g = p;
            end
        end

        chk({t, ".req_ready"}, 64'(rdy_obs[i]), (g >= 0) ? 64'(1) << g : 64'(0));
        chk({t, ".mem_en"},    64'(en_obs[i]),    64'(e_en[i]));
        chk({t, ".mem_we"},    64'(we_obs[i]),    64'(e_we[i]));
        chk({t, ".mem_addr"},  64'(maddr_obs[i]), 64'(e_addr[i]));
        chk({t, ".mem_wdata"}, 64'(mwd_obs[i]),   64'(e_wdata[i]));

        idx = -1;
        for (int k = 0; k < rq.size(); k++)
            if (idx < 0 && rq[k].inst == i) idx = k;
        exp_rv = '0;
        if (idx >= 0 && rq[idx].due == c) begin
            exp_rv = N'(1) << rq[idx].port;
            chk({t, ".rsp_rdata"}, 64'(rspd_obs[i]), 64'(rq[idx].data));
            rq.delete(idx);
        end
        chk({t, ".rsp_valid"}, 64'(rspv_obs[i]), 64'(exp_rv));
        if (rst_last)
            chk({t, ".rsp_rdata_rst"}, 64'(rspd_obs[i]), 64'(0));
        chk({t, ".conflict_cnt"}, 64'(cnt_obs[i]), 64'(cnt[i]));

        for (int p = 0; p < N; p++) gnt_flag[i][p] = (p == g);

        if (rst) begin
            ptr[i]     = 0;
            cnt[i]     = 0;
            e_en[i]    = 1'b0;
            e_we[i]    = 1'b0;
            e_addr[i]  = 0;
            e_wdata[i] = '0;
            for (int k = rq.size() - 1; k >= 0; k--)
                if (rq[k].inst == i) rq.delete(k);
        end else begin
            if (g >= 0) begin
                loc        = int'(addr_s[i][g]) - lo_of(i);
                e_en[i]    = 1'b1;
                e_we[i]    = we_s[i][g];
                e_addr[i]  = loc;
                e_wdata[i] = wdata_s[i][g];
                if (we_s[i][g]) ref_mem[i][loc] = wdata_s[i][g];
                else rq.push_back('{inst: i, due: c + 2 + lat_of(i), port: g, data: ref_mem[i][loc]});
                if (rr_of(i)) ptr[i] = (g + 1) % N;
            end else begin
                e_en[i] = 1'b0;
                e_we[i] = 1'b0;
            end
            if (ne >= 2 && cnt[i] < max_of(i)) cnt[i] = cnt[i] + 1;
        end
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) begin
            logic [DW-1:0] v0, v1;
            v0 = $urandom;
            v1 = $urandom;
            bmem0[a] = v0;
            bmem1[a] = v1;
            ref_mem[0][a] = v0;
            ref_mem[1][a] = v1;
        end
        for (int i = 0; i < 2; i++) begin
            ptr[i] = 0; cnt[i] = 0; e_en[i] = 1'b0; e_we[i] = 1'b0; e_addr[i] = 0; e_wdata[i] = '0;
            valid_s[i] = '0;
            we_s[i]    = '0;
            for (int p = 0; p < N; p++) begin
                pend[i][p] = 1'b0; gnt_flag[i][p] = 1'b0; addr_s[i][p] = '0; wdata_s[i][p] = '0;
            end
        end
        rst_last = 1'b1;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            cyc_now = c;
            rst = (c < 3) || (c >= 400 && c < 402) || (c == 1200);
            drive_inst(0, c);
            drive_inst(1, c);
            @(negedge clk);
            check_and_step(0, c);
            check_and_step(1, c);
            rst_last = rst;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
